// File: rtl/line_serializer_pkg.sv
// Shared types and constants for the line serializer.
// Lines are held as packed arrays of elements, with element 0 transmitted first.
package line_serializer_pkg;

  localparam int DATA_W   = 8;
  localparam int LINE_LEN = 4;
  localparam int IDX_W    = 2;

  // Value driven on data_out (and held in empty line registers) when no element is valid.
  localparam logic [DATA_W-1:0] NONDATA = '0;

  // Index of the final element of a line; reaching it ends the line.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  typedef logic [DATA_W-1:0]  elem_t;
  typedef elem_t [LINE_LEN-1:0] line_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Gather the four parallel inputs into one line, data1 landing in slot 0.
  function automatic line_t pack_line(input elem_t d1, input elem_t d2,
                                      input elem_t d3, input elem_t d4);
    line_t l;
    l[0] = d1;
    l[1] = d2;
    l[2] = d3;
    l[3] = d4;
    return l;
  endfunction

  // Contents of a line register that holds no line.
  function automatic line_t empty_line();
    return {LINE_LEN{NONDATA}};
  endfunction

endpackage

// File: rtl/line_serializer_line_reg.sv
// One 4-element line holding register with a full flag.
// load_i captures din_i and sets full; clear_i drops full without touching the data.
// Reset empties the register and returns every element to NONDATA.
module line_serializer_line_reg
  import line_serializer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  clear_i,
  input  line_t din_i,
  output line_t dout_o,
  output logic  full_o
);

  line_t data_q;
  logic  full_q;

  // Capture a line on load; load wins over clear when both are requested.
  // NOTE: the line storage is reset along with the flag so data_out reads NONDATA
  // straight out of reset instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= empty_line();
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= din_i;
      full_q <= 1'b1;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  assign dout_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/line_serializer.sv
// line_serializer: takes a 4-element line in parallel and emits it one element per
// transfer on a valid/ready stream, data1 first, with last_out on the fourth element.
// Optional feature macro: LINE_SERIALIZER_PINGPONG_EN adds a shadow line register so a
// following line can be accepted while the current one drains, giving gap-free output.
// Without it, a new line is accepted only from IDLE (one idle cycle between lines).
module line_serializer
  import line_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              out_ready,
  output logic              last_out,
  output logic              busy
);

  state_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  line_t in_line;
  line_t main_din;
  line_t main_line;
  logic  main_load;
  logic  main_clear;
  logic  main_full;
  logic  shadow_full;

  logic  accept;
  logic  transfer;

  assign in_line = pack_line(data1, data2, data3, data4);

  // Main register: the line currently being serialized. It is full exactly while in SEND.
  line_serializer_line_reg u_main (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .din_i   (main_din),
    .dout_o  (main_line),
    .full_o  (main_full)
  );

`ifdef LINE_SERIALIZER_PINGPONG_EN
  logic  shadow_load;
  logic  shadow_clear;
  line_t shadow_line;

  // Shadow register: parks the next line until the main line's last element leaves.
  line_serializer_line_reg u_shadow (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (shadow_load),
    .clear_i (shadow_clear),
    .din_i   (in_line),
    .dout_o  (shadow_line),
    .full_o  (shadow_full)
  );

  assign line_ready = !shadow_full;
`else
  assign shadow_full = 1'b0;
  assign line_ready  = (state_q == ST_IDLE);
`endif

  assign accept   = line_valid & line_ready;
  // Transfer is derived from state rather than valid_out so the next-state logic below
  // does not read back one of its own outputs.
  assign transfer = (state_q == ST_SEND) & out_ready;

  assign busy = main_full | shadow_full;

  // State and element-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state, register controls and stream outputs.
  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_din   = in_line;
`ifdef LINE_SERIALIZER_PINGPONG_EN
    shadow_load  = 1'b0;
    shadow_clear = 1'b0;
`endif
    valid_out  = 1'b0;
    last_out   = 1'b0;
    data_out   = NONDATA;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          main_load = 1'b1;
          idx_d     = '0;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        valid_out = 1'b1;
        data_out  = main_line[idx_q];
        last_out  = (idx_q == LAST_IDX);

        if (transfer) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
`ifdef LINE_SERIALIZER_PINGPONG_EN
            if (shadow_full) begin
              // Pending line moves up; stay in SEND so there is no bubble.
              main_din     = shadow_line;
              main_load    = 1'b1;
              shadow_clear = 1'b1;
            end else if (accept) begin
              // A line arriving on the very last transfer goes straight to main.
              main_load = 1'b1;
            end else begin
              main_clear = 1'b1;
              state_d    = ST_IDLE;
            end
`else
            main_clear = 1'b1;
            state_d    = ST_IDLE;
`endif
          end
        end

`ifdef LINE_SERIALIZER_PINGPONG_EN
        // Any other accept while sending is parked in the shadow register.
        if (accept && !main_load) begin
          shadow_load = 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_serializer.sv
// Self-checking bench for line_serializer. A queue of expected elements models the
// stream: an accepted line appends its four elements, a transfer removes the head.
// Outputs and line_ready are predicted from the queue depth alone.
module tb_line_serializer;

  localparam logic [7:0] NONDATA = 8'h00;
`ifdef LINE_SERIALIZER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       line_valid;
  logic       line_ready;
  logic [7:0] data1, data2, data3, data4;
  logic [7:0] data_out;
  logic       valid_out;
  logic       out_ready;
  logic       last_out;
  logic       busy;

  line_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .data4      (data4),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .last_out   (last_out),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t q[$];
  bit   vlog[$];
  bit   last_acc;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready is predicted from how many elements are still owed downstream:
  // with a shadow register, a new line fits whenever at most one line is outstanding.
  function automatic bit exp_ready();
    if (PP) return q.size() <= 4;
    return q.size() == 0;
  endfunction

  // Check one cycle's outputs against the model, then advance one clock edge.
  task automatic tick();
    bit         has;
    bit         acc;
    bit         xfer;
    logic [7:0] ln [4];
    has = (q.size() != 0);
    check("valid_out", valid_out, has);
    check("busy", busy, has);
    check("line_ready", line_ready, exp_ready());
    check("last_out", last_out, has ? q[0].last : 1'b0);
    check("data_out", data_out, has ? q[0].d : NONDATA);
    acc  = line_valid && exp_ready();
    xfer = has && out_ready;
    ln   = '{data1, data2, data3, data4};
    vlog.push_back(valid_out);
    @(posedge clk);
    if (xfer) void'(q.pop_front());
    if (acc) begin
      for (int i = 0; i < 4; i++) q.push_back('{ln[i], (i == 3)});
    end
    last_acc = acc;
    #1;
  endtask

  task automatic set_line(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    data1 = a;
    data2 = b;
    data3 = c;
    data4 = d;
  endtask

  initial begin
    logic [7:0] exp1 [4];
    int         first1, last1, ones, gaps;
    int         sent;
    bit         b_taken;

    exp1 = '{8'd11, 8'd22, 8'd33, 8'd44};
    rst = 1'b0;
    line_valid = 1'b0;
    out_ready = 1'b0;
    set_line(8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", valid_out, 1'b0);
    check("rst_last", last_out, 1'b0);
    check("rst_data", data_out, NONDATA);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", line_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: one line, downstream always ready
    set_line(8'd11, 8'd22, 8'd33, 8'd44);
    out_ready  = 1'b1;
    line_valid = 1'b1;
    tick();
    check("t1_accept", last_acc, 1'b1);
    line_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_data", data_out, exp1[k]);
      check("t1_valid", valid_out, 1'b1);
      check("t1_last", last_out, (k == 3));
      tick();
    end
    check("t1_idle_valid", valid_out, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // Test 2: stall while element 22 is presented
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_data", data_out, 8'd22);
      check("t2_hold_valid", valid_out, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t2_resume", data_out, 8'd33);
    tick();
    check("t2_last", last_out, 1'b1);
    tick();
    check("t2_idle", valid_out, 1'b0);

    // Test 3: two lines back to back
    set_line(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    line_valid = 1'b1;
    tick();
    set_line(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    vlog.delete();
    b_taken = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (last_acc && line_valid) begin
        b_taken = 1'b1;
        line_valid = 1'b0;
      end
    end
    line_valid = 1'b0;
    check("t3_b_accepted", b_taken, 1'b1);
    first1 = -1;
    last1  = -1;
    ones   = 0;
    foreach (vlog[i]) begin
      if (vlog[i]) begin
        if (first1 < 0) first1 = i;
        last1 = i;
        ones++;
      end
    end
    gaps = (first1 < 0) ? -1 : (last1 - first1 + 1 - ones);
    check("t3_elements", ones, 8);
    check("t3_gap", gaps, PP ? 0 : 1);

    // Test 4: a line offered while not ready is ignored
    set_line(8'h41, 8'h42, 8'h43, 8'h44);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    if (PP) begin
      set_line(8'h51, 8'h52, 8'h53, 8'h54);
      line_valid = 1'b1;
      tick();
    end else begin
      tick();
    end
    set_line(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    line_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("t4_not_ready", line_ready, 1'b0);
      tick();
    end
    line_valid = 1'b0;
    repeat (10) tick();
    check("t4_drained", busy, 1'b0);

    // Test 5: reset after the second element, with a pending line offered
    set_line(8'h61, 8'h62, 8'h63, 8'h64);
    line_valid = 1'b1;
    tick();
    set_line(8'h71, 8'h72, 8'h73, 8'h74);
    tick();
    line_valid = 1'b0;
    tick();
    check("t5_pre_data", data_out, 8'h63);
    rst = 1'b0;
    #1;
    q.delete();
    check("t5_valid", valid_out, 1'b0);
    check("t5_data", data_out, NONDATA);
    check("t5_ready", line_ready, 1'b1);
    check("t5_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) tick();

    // Random lines with random downstream back-pressure; the sender holds each line
    sent = 0;
    line_valid = 1'b0;
    for (int c = 0; c < 3000 && (sent < 40 || q.size() != 0); c++) begin
      if (!line_valid) begin
        set_line(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        if (sent < 40 && ($urandom % 3) != 0) line_valid = 1'b1;
      end
      out_ready = ($urandom % 4) != 0;
      tick();
      if (last_acc) begin
        line_valid = 1'b0;
        sent++;
      end
    end
    check("rand_lines_sent", sent, 40);
    check("rand_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
